// File: rtl/sram_pkg.sv
// Shared types and sizes for the SRAM arbiter and its bank decoder.
package sram_pkg;

    localparam int BANKS   = 4;
    localparam int ADDR_W  = 21;
    localparam int WADDR_W = 19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWN_VID = 1'b0,
        OWN_CPU = 1'b1
    } owner_t;

endpackage

// File: rtl/sram_bank_decode.sv
// Bank chip-enable decode and byte-lane selection from the top two address bits.
module sram_bank_decode
    import sram_pkg::*;
(
    input  logic [1:0]       i_bank,
    output logic [BANKS-1:0] o_ceN,
    output logic             o_laneHigh,
    output logic [1:0]       o_dqOeMask
);

    // One active-low enable per bank; odd banks use the high byte lane
    always_comb begin
        o_ceN         = '1;
        o_ceN[i_bank] = 1'b0;
        o_laneHigh    = i_bank[0];
        o_dqOeMask    = i_bank[0] ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter (video read-only, CPU read/write) sequencing a 4-bank byte-wide SRAM.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int RD_WAIT  = 2,
    parameter int WR_PULSE = 2
) (
    input  logic               clk_100,
    input  logic               reset_n,
    input  logic               vid_req,
    input  logic [ADDR_W-1:0]  vid_addr,
    output logic               vid_ack,
    output logic [7:0]         vid_rdata,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic               cpu_ack,
    output logic [7:0]         cpu_rdata,
    output logic [WADDR_W-1:0] sram_a,
    output logic [15:0]        sram_dq_out,
    output logic [1:0]         sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic [BANKS-1:0]   sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               busy
);

    state_t              r_state, w_stateNext;
    owner_t              r_owner, w_ownerNext;
    owner_t              r_rrLast, w_rrLastNext;
    logic [3:0]          r_cnt, w_cntNext;
    logic                r_lane, w_laneNext;
    logic [WADDR_W-1:0]  r_sramA, w_sramANext;
    logic [15:0]         r_dqOut, w_dqOutNext;
    logic [1:0]          r_dqOe, w_dqOeNext;
    logic [BANKS-1:0]    r_ceN, w_ceNNext;
    logic                r_oeN, w_oeNNext;
    logic                r_weN, w_weNNext;
    logic                r_vidAck, w_vidAckNext;
    logic                r_cpuAck, w_cpuAckNext;
    logic [7:0]          r_vidRdata, w_vidRdataNext;
    logic [7:0]          r_cpuRdata, w_cpuRdataNext;

    logic                w_grantValid;
    logic                w_grantCpu;
    logic [ADDR_W-1:0]   w_grantAddr;
    logic [BANKS-1:0]    w_decCeN;
    logic                w_decLane;
    logic [1:0]          w_decMask;
    logic [7:0]          w_rdByte;

    // A lone requester wins; on a tie the port that did not own the bus last time wins
    assign w_grantValid = vid_req | cpu_req;
    assign w_grantCpu   = cpu_req & (~vid_req | (r_rrLast == OWN_VID));
    assign w_grantAddr  = w_grantCpu ? cpu_addr : vid_addr;
    assign w_rdByte     = r_lane ? sram_dq_in[15:8] : sram_dq_in[7:0];

    sram_bank_decode u_decode (
        .i_bank     (w_grantAddr[ADDR_W-1 -: 2]),
        .o_ceN      (w_decCeN),
        .o_laneHigh (w_decLane),
        .o_dqOeMask (w_decMask)
    );

    // State register and every pin driver; reset releases the bus immediately
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_VID;
            r_rrLast   <= OWN_CPU;
            r_cnt      <= '0;
            r_lane     <= 1'b0;
            r_sramA    <= '0;
            r_dqOut    <= '0;
            r_dqOe     <= '0;
            r_ceN      <= '1;
            r_oeN      <= 1'b1;
            r_weN      <= 1'b1;
            r_vidAck   <= 1'b0;
            r_cpuAck   <= 1'b0;
            r_vidRdata <= '0;
            r_cpuRdata <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_owner    <= w_ownerNext;
            r_rrLast   <= w_rrLastNext;
            r_cnt      <= w_cntNext;
            r_lane     <= w_laneNext;
            r_sramA    <= w_sramANext;
            r_dqOut    <= w_dqOutNext;
            r_dqOe     <= w_dqOeNext;
            r_ceN      <= w_ceNNext;
            r_oeN      <= w_oeNNext;
            r_weN      <= w_weNNext;
            r_vidAck   <= w_vidAckNext;
            r_cpuAck   <= w_cpuAckNext;
            r_vidRdata <= w_vidRdataNext;
            r_cpuRdata <= w_cpuRdataNext;
        end
    end

    // Next-state and next pin values; each state's pin action lands at the edge leaving it
    always_comb begin
        w_stateNext    = r_state;
        w_ownerNext    = r_owner;
        w_rrLastNext   = r_rrLast;
        w_cntNext      = r_cnt;
        w_laneNext     = r_lane;
        w_sramANext    = r_sramA;
        w_dqOutNext    = r_dqOut;
        w_dqOeNext     = r_dqOe;
        w_ceNNext      = r_ceN;
        w_oeNNext      = r_oeN;
        w_weNNext      = r_weN;
        w_vidAckNext   = 1'b0;
        w_cpuAckNext   = 1'b0;
        w_vidRdataNext = r_vidRdata;
        w_cpuRdataNext = r_cpuRdata;

        case (r_state)
            ST_IDLE: begin
                if (w_grantValid) begin
                    w_ownerNext  = w_grantCpu ? OWN_CPU : OWN_VID;
                    w_rrLastNext = w_grantCpu ? OWN_CPU : OWN_VID;
                    w_laneNext   = w_decLane;
                    w_sramANext  = w_grantAddr[WADDR_W-1:0];
                    w_ceNNext    = w_decCeN;
                    if (w_grantCpu && cpu_we) begin
                        w_dqOeNext  = w_decMask;
                        w_dqOutNext = {cpu_wdata, cpu_wdata};
                        w_stateNext = ST_WR_SETUP;
                    end else begin
                        w_oeNNext   = 1'b0;
                        w_cntNext   = 4'(RD_WAIT - 1);
                        w_stateNext = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (r_cnt == 4'd0) begin
                    if (r_owner == OWN_CPU) begin
                        w_cpuRdataNext = w_rdByte;
                    end else begin
                        w_vidRdataNext = w_rdByte;
                    end
                    w_stateNext = ST_DONE;
                end else begin
                    w_cntNext = r_cnt - 4'd1;
                end
            end
            ST_WR_SETUP: begin
                w_cntNext   = 4'(WR_PULSE - 1);
                w_stateNext = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                w_weNNext = 1'b0;
                if (r_cnt == 4'd0) begin
                    w_stateNext = ST_WR_HOLD;
                end else begin
                    w_cntNext = r_cnt - 4'd1;
                end
            end
            ST_WR_HOLD: begin
                w_weNNext   = 1'b1;
                w_stateNext = ST_DONE;
            end
            ST_DONE: begin
                w_vidAckNext = (r_owner == OWN_VID);
                w_cpuAckNext = (r_owner == OWN_CPU);
                w_ceNNext    = '1;
                w_oeNNext    = 1'b1;
                w_dqOeNext   = '0;
                w_stateNext  = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign sram_a      = r_sramA;
    assign sram_dq_out = r_dqOut;
    assign sram_dq_oe  = r_dqOe;
    assign sram_ce_n   = r_ceN;
    assign sram_oe_n   = r_oeN;
    assign sram_we_n   = r_weN;
    assign vid_ack     = r_vidAck;
    assign cpu_ack     = r_cpuAck;
    assign vid_rdata   = r_vidRdata;
    assign cpu_rdata   = r_cpuRdata;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default-timing instance plus a RD_WAIT=4/WR_PULSE=1 instance.
module tb_sram_arbiter;

    logic        clk_100 = 1'b0;
    logic        reset_n;

    logic        vid_req, cpu_req, cpu_we;
    logic [20:0] vid_addr, cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        vid_ack, cpu_ack;
    logic [7:0]  vid_rdata, cpu_rdata;
    logic [18:0] sram_a;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in = 16'h0000;
    logic [1:0]  sram_dq_oe;
    logic [3:0]  sram_ce_n;
    logic        sram_oe_n, sram_we_n, busy;

    logic        d2_vid_req, d2_cpu_req, d2_cpu_we;
    logic [20:0] d2_vid_addr, d2_cpu_addr;
    logic [7:0]  d2_cpu_wdata;
    logic        d2_vid_ack, d2_cpu_ack;
    logic [7:0]  d2_vid_rdata, d2_cpu_rdata;
    logic [18:0] d2_sram_a;
    logic [15:0] d2_dq_out, d2_dq_in;
    logic [1:0]  d2_dq_oe;
    logic [3:0]  d2_ce_n;
    logic        d2_oe_n, d2_we_n, d2_busy;

    int          passCount = 0;
    int          checkCount = 0;
    int          exclViol = 0;

    int          obsAckCycle, obsAckCount, obsWeFirst, obsWeLast, obsWeCount;
    logic [3:0]  obsCe0;
    logic [18:0] obsA0;
    logic [1:0]  obsDqOe0;
    logic [15:0] obsDqOut0;
    logic        obsOe0, obsBusy0;

    logic [15:0] mem [logic [20:0]];

    always #5 clk_100 = ~clk_100;

    sram_arbiter dut (
        .clk_100     (clk_100),
        .reset_n     (reset_n),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_ack     (vid_ack),
        .vid_rdata   (vid_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .sram_a      (sram_a),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .busy        (busy)
    );

    sram_arbiter #(.RD_WAIT(4), .WR_PULSE(1)) dut2 (
        .clk_100     (clk_100),
        .reset_n     (reset_n),
        .vid_req     (d2_vid_req),
        .vid_addr    (d2_vid_addr),
        .vid_ack     (d2_vid_ack),
        .vid_rdata   (d2_vid_rdata),
        .cpu_req     (d2_cpu_req),
        .cpu_we      (d2_cpu_we),
        .cpu_addr    (d2_cpu_addr),
        .cpu_wdata   (d2_cpu_wdata),
        .cpu_ack     (d2_cpu_ack),
        .cpu_rdata   (d2_cpu_rdata),
        .sram_a      (d2_sram_a),
        .sram_dq_out (d2_dq_out),
        .sram_dq_oe  (d2_dq_oe),
        .sram_dq_in  (d2_dq_in),
        .sram_ce_n   (d2_ce_n),
        .sram_oe_n   (d2_oe_n),
        .sram_we_n   (d2_we_n),
        .busy        (d2_busy)
    );

    // The second instance sees a fixed word whenever its output enable is asserted
    assign d2_dq_in = (!d2_oe_n) ? 16'hBEEF : 16'h0000;

    function automatic int bankOf(input logic [3:0] ce);
        for (int i = 0; i < 4; i++) begin
            if (ce[i] == 1'b0) return i;
        end
        return -1;
    endfunction

    // Byte-lane SRAM model for the first instance, updated on the falling edge
    always @(negedge clk_100) begin
        int          b;
        logic [20:0] key;
        logic [15:0] word;
        b    = bankOf(sram_ce_n);
        key  = {b[1:0], sram_a};
        word = mem.exists(key) ? mem[key] : 16'h0000;
        if (b >= 0 && !sram_we_n) begin
            if (sram_dq_oe[1]) word[15:8] = sram_dq_out[15:8];
            if (sram_dq_oe[0]) word[7:0]  = sram_dq_out[7:0];
            mem[key] = word;
        end
        sram_dq_in <= (b >= 0 && !sram_oe_n) ? word : 16'h0000;
    end

    // Output enable and write enable must never overlap, and only one lane may drive
    always @(negedge clk_100) begin
        assert (sram_oe_n || sram_we_n) else begin
            $display("[TB] FAIL oe_we_overlap dut: oe_n=%b we_n=%b required not both 0", sram_oe_n, sram_we_n);
            exclViol++;
        end
        assert (d2_oe_n || d2_we_n) else begin
            $display("[TB] FAIL oe_we_overlap dut2: oe_n=%b we_n=%b required not both 0", d2_oe_n, d2_we_n);
            exclViol++;
        end
        assert (sram_dq_oe != 2'b11 && d2_dq_oe != 2'b11) else begin
            $display("[TB] FAIL dual_lane: dq_oe=%b/%b required not 11", sram_dq_oe, d2_dq_oe);
            exclViol++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    // Raise one request on the first instance and record what happens cycle by cycle
    task automatic applyStimulus(input bit isCpu, input bit we, input logic [20:0] addr,
                                 input logic [7:0] wdata, input bit dropAtGrant, input int nCycles);
        logic ack;
        @(negedge clk_100);
        if (isCpu) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            vid_req = 1'b1; vid_addr = addr;
        end
        obsAckCycle = -1; obsAckCount = 0; obsWeFirst = -1; obsWeLast = -1; obsWeCount = 0;
        for (int c = 0; c < nCycles; c++) begin
            @(posedge clk_100); #1;
            if (c == 0) begin
                obsCe0 = sram_ce_n; obsA0 = sram_a; obsDqOe0 = sram_dq_oe;
                obsDqOut0 = sram_dq_out; obsOe0 = sram_oe_n; obsBusy0 = busy;
                if (dropAtGrant) begin
                    cpu_req = 1'b0; vid_req = 1'b0;
                end
            end
            ack = isCpu ? cpu_ack : vid_ack;
            if (ack) begin
                if (obsAckCycle < 0) obsAckCycle = c;
                obsAckCount++;
                if (isCpu) cpu_req = 1'b0; else vid_req = 1'b0;
            end
            if (!sram_we_n) begin
                if (obsWeFirst < 0) obsWeFirst = c;
                obsWeLast = c;
                obsWeCount++;
            end
        end
        cpu_req = 1'b0; vid_req = 1'b0;
    endtask

    // Same recording for the slow-timing instance
    task automatic runDut2(input bit isCpu, input bit we, input logic [20:0] addr, input int nCycles);
        logic ack;
        @(negedge clk_100);
        if (isCpu) begin
            d2_cpu_req = 1'b1; d2_cpu_we = we; d2_cpu_addr = addr; d2_cpu_wdata = 8'h3C;
        end else begin
            d2_vid_req = 1'b1; d2_vid_addr = addr;
        end
        obsAckCycle = -1; obsAckCount = 0; obsWeFirst = -1; obsWeCount = 0;
        for (int c = 0; c < nCycles; c++) begin
            @(posedge clk_100); #1;
            if (c == 0) obsCe0 = d2_ce_n;
            ack = isCpu ? d2_cpu_ack : d2_vid_ack;
            if (ack) begin
                if (obsAckCycle < 0) obsAckCycle = c;
                obsAckCount++;
                d2_cpu_req = 1'b0; d2_vid_req = 1'b0;
            end
            if (!d2_we_n) begin
                if (obsWeFirst < 0) obsWeFirst = c;
                obsWeCount++;
            end
        end
        d2_cpu_req = 1'b0; d2_vid_req = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk_100);
        #1;
        checkCount++; if ({sram_we_n, sram_oe_n} !== 2'b11) $display("[TB] FAIL reset_we_oe: got %b expected 11", {sram_we_n, sram_oe_n}); else passCount++;
        checkCount++; if (sram_ce_n !== 4'hF) $display("[TB] FAIL reset_ce_n: got %h expected F", sram_ce_n); else passCount++;
        checkCount++; if (sram_dq_oe !== 2'b00) $display("[TB] FAIL reset_dq_oe: got %b expected 00", sram_dq_oe); else passCount++;
        checkCount++; if (sram_a !== 19'h0) $display("[TB] FAIL reset_sram_a: got %h expected 0", sram_a); else passCount++;
        checkCount++; if (sram_dq_out !== 16'h0) $display("[TB] FAIL reset_dq_out: got %h expected 0", sram_dq_out); else passCount++;
        checkCount++; if ({vid_ack, cpu_ack} !== 2'b00) $display("[TB] FAIL reset_acks: got %b expected 00", {vid_ack, cpu_ack}); else passCount++;
        checkCount++; if ({vid_rdata, cpu_rdata} !== 16'h0) $display("[TB] FAIL reset_rdata: got %h expected 0", {vid_rdata, cpu_rdata}); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
        @(negedge clk_100);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_100);
    endtask

    task automatic test_video_read;
        mem[{2'd1, 19'h00005}] = 16'hAB12;
        applyStimulus(1'b0, 1'b0, 21'h080005, 8'h00, 1'b0, 10);
        checkCount++; if (obsCe0 !== 4'b1101) $display("[TB] FAIL vrd_ce_n: got %b expected 1101", obsCe0); else passCount++;
        checkCount++; if (obsA0 !== 19'h00005) $display("[TB] FAIL vrd_sram_a: got %h expected 00005", obsA0); else passCount++;
        checkCount++; if (obsOe0 !== 1'b0) $display("[TB] FAIL vrd_oe_n: got %b expected 0", obsOe0); else passCount++;
        checkCount++; if (obsBusy0 !== 1'b1) $display("[TB] FAIL vrd_busy: got %b expected 1", obsBusy0); else passCount++;
        checkCount++; if (obsAckCycle !== 3) $display("[TB] FAIL vrd_ack_cycle: got %0d expected 3", obsAckCycle); else passCount++;
        checkCount++; if (obsAckCount !== 1) $display("[TB] FAIL vrd_ack_count: got %0d expected 1", obsAckCount); else passCount++;
        checkCount++; if (vid_rdata !== 8'hAB) $display("[TB] FAIL vrd_rdata: got %h expected AB", vid_rdata); else passCount++;
        checkCount++; if (cpu_rdata !== 8'h00) $display("[TB] FAIL vrd_cpu_rdata_hold: got %h expected 00", cpu_rdata); else passCount++;
    endtask

    task automatic test_cpu_write_readback;
        applyStimulus(1'b1, 1'b1, 21'h100010, 8'h5A, 1'b0, 10);
        checkCount++; if (obsCe0 !== 4'b1011) $display("[TB] FAIL wr_ce_n: got %b expected 1011", obsCe0); else passCount++;
        checkCount++; if (obsDqOe0 !== 2'b01) $display("[TB] FAIL wr_dq_oe: got %b expected 01", obsDqOe0); else passCount++;
        checkCount++; if (obsDqOut0 !== 16'h5A5A) $display("[TB] FAIL wr_dq_out: got %h expected 5A5A", obsDqOut0); else passCount++;
        checkCount++; if (obsOe0 !== 1'b1) $display("[TB] FAIL wr_oe_n: got %b expected 1", obsOe0); else passCount++;
        checkCount++; if (obsWeFirst !== 2) $display("[TB] FAIL wr_we_first: got %0d expected 2", obsWeFirst); else passCount++;
        checkCount++; if (obsWeLast !== 3) $display("[TB] FAIL wr_we_last: got %0d expected 3", obsWeLast); else passCount++;
        checkCount++; if (obsWeCount !== 2) $display("[TB] FAIL wr_we_count: got %0d expected 2", obsWeCount); else passCount++;
        checkCount++; if (obsAckCycle !== 5) $display("[TB] FAIL wr_ack_cycle: got %0d expected 5", obsAckCycle); else passCount++;
        checkCount++; if (obsAckCount !== 1) $display("[TB] FAIL wr_ack_count: got %0d expected 1", obsAckCount); else passCount++;
        applyStimulus(1'b1, 1'b0, 21'h100010, 8'h00, 1'b0, 10);
        checkCount++; if (obsAckCycle !== 3) $display("[TB] FAIL rb_ack_cycle: got %0d expected 3", obsAckCycle); else passCount++;
        checkCount++; if (cpu_rdata !== 8'h5A) $display("[TB] FAIL rb_rdata: got %h expected 5A", cpu_rdata); else passCount++;
        checkCount++; if (vid_rdata !== 8'hAB) $display("[TB] FAIL rb_vid_rdata_hold: got %h expected AB", vid_rdata); else passCount++;
    endtask

    task automatic test_alternation;
        int   seq [6];
        int   n;
        bit   sawBank3;
        int   expSeq [6];
        expSeq = '{0, 1, 0, 1, 0, 1};
        mem[{2'd0, 19'h00020}] = 16'h3344;
        mem[{2'd3, 19'h7FFFF}] = 16'hC7D8;
        @(negedge clk_100); reset_n = 1'b0;
        @(negedge clk_100); reset_n = 1'b1;
        @(negedge clk_100);
        vid_req = 1'b1; vid_addr = 21'h000020;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h1FFFFF;
        n = 0; sawBank3 = 1'b0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(posedge clk_100); #1;
            if (sram_ce_n == 4'b0111 && sram_a == 19'h7FFFF) sawBank3 = 1'b1;
            if (vid_ack && n < 6) begin seq[n] = 0; n++; end
            if (cpu_ack && n < 6) begin seq[n] = 1; n++; end
        end
        vid_req = 1'b0; cpu_req = 1'b0;
        checkCount++; if (n !== 6) $display("[TB] FAIL alt_count: got %0d expected 6", n); else passCount++;
        for (int i = 0; i < 6; i++) begin
            if (i < n) begin
                checkCount++; if (seq[i] !== expSeq[i]) $display("[TB] FAIL alt_order[%0d]: got %0d expected %0d", i, seq[i], expSeq[i]); else passCount++;
            end
        end
        checkCount++; if (vid_rdata !== 8'h44) $display("[TB] FAIL alt_vid_rdata: got %h expected 44", vid_rdata); else passCount++;
        checkCount++; if (cpu_rdata !== 8'hC7) $display("[TB] FAIL alt_cpu_rdata_top: got %h expected C7", cpu_rdata); else passCount++;
        checkCount++; if (sawBank3 !== 1'b1) $display("[TB] FAIL alt_bank3_decode: got %b expected 1", sawBank3); else passCount++;
        repeat (3) @(negedge clk_100);
    endtask

    task automatic test_drop_mid_access;
        applyStimulus(1'b1, 1'b1, 21'h000044, 8'h77, 1'b1, 14);
        checkCount++; if (obsAckCount !== 1) $display("[TB] FAIL drop_ack_count: got %0d expected 1", obsAckCount); else passCount++;
        checkCount++; if (obsAckCycle !== 5) $display("[TB] FAIL drop_ack_cycle: got %0d expected 5", obsAckCycle); else passCount++;
        checkCount++; if (obsWeCount !== 2) $display("[TB] FAIL drop_we_count: got %0d expected 2", obsWeCount); else passCount++;
    endtask

    task automatic test_reset_mid_write;
        int acks;
        @(negedge clk_100);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 21'h180008; cpu_wdata = 8'h99;
        repeat (3) @(posedge clk_100);
        #1;
        checkCount++; if (sram_we_n !== 1'b0) $display("[TB] FAIL rmw_we_low_before: got %b expected 0", sram_we_n); else passCount++;
        reset_n = 1'b0;
        #1;
        checkCount++; if (sram_we_n !== 1'b1) $display("[TB] FAIL rmw_we_n: got %b expected 1", sram_we_n); else passCount++;
        checkCount++; if (sram_ce_n !== 4'hF) $display("[TB] FAIL rmw_ce_n: got %h expected F", sram_ce_n); else passCount++;
        checkCount++; if (sram_dq_oe !== 2'b00) $display("[TB] FAIL rmw_dq_oe: got %b expected 00", sram_dq_oe); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rmw_busy: got %b expected 0", busy); else passCount++;
        cpu_req = 1'b0;
        @(negedge clk_100);
        reset_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_100); #1;
            if (cpu_ack) acks++;
        end
        checkCount++; if (acks !== 0) $display("[TB] FAIL rmw_no_ack: got %0d expected 0", acks); else passCount++;
        applyStimulus(1'b0, 1'b0, 21'h080005, 8'h00, 1'b0, 10);
        checkCount++; if (obsAckCycle !== 3) $display("[TB] FAIL rmw_next_ack_cycle: got %0d expected 3", obsAckCycle); else passCount++;
        checkCount++; if (vid_rdata !== 8'hAB) $display("[TB] FAIL rmw_next_rdata: got %h expected AB", vid_rdata); else passCount++;
    endtask

    task automatic test_slow_timing;
        runDut2(1'b0, 1'b0, 21'h000003, 12);
        checkCount++; if (obsCe0 !== 4'b1110) $display("[TB] FAIL slow_rd_ce_n: got %b expected 1110", obsCe0); else passCount++;
        checkCount++; if (obsAckCycle !== 5) $display("[TB] FAIL slow_rd_ack_cycle: got %0d expected 5", obsAckCycle); else passCount++;
        checkCount++; if (d2_vid_rdata !== 8'hEF) $display("[TB] FAIL slow_rd_rdata: got %h expected EF", d2_vid_rdata); else passCount++;
        runDut2(1'b1, 1'b1, 21'h000003, 12);
        checkCount++; if (obsAckCycle !== 4) $display("[TB] FAIL slow_wr_ack_cycle: got %0d expected 4", obsAckCycle); else passCount++;
        checkCount++; if (obsWeCount !== 1) $display("[TB] FAIL slow_wr_we_count: got %0d expected 1", obsWeCount); else passCount++;
        checkCount++; if (obsWeFirst !== 2) $display("[TB] FAIL slow_wr_we_first: got %0d expected 2", obsWeFirst); else passCount++;
        checkCount++; if (d2_busy !== 1'b0) $display("[TB] FAIL slow_busy_after: got %b expected 0", d2_busy); else passCount++;
    endtask

    task automatic test_exclusion;
        checkCount++; if (exclViol !== 0) $display("[TB] FAIL exclusion_violations: got %0d expected 0", exclViol); else passCount++;
    endtask

    // Scenario sequence
    initial begin
        reset_n = 1'b0;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        d2_vid_req = 1'b0; d2_vid_addr = '0;
        d2_cpu_req = 1'b0; d2_cpu_we = 1'b0; d2_cpu_addr = '0; d2_cpu_wdata = '0;
        $display("[TB] starting sram_arbiter bench");
        test_reset;
        test_video_read;
        test_cpu_write_readback;
        test_alternation;
        test_drop_mid_access;
        test_reset_mid_write;
        test_slow_timing;
        test_exclusion;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
